fib_bcd_display: RTL and testbench
==================================

// Module: fib_bcd_display
// PURPOSE
// - Downstream stage of the Fibonacci generator: consumes its 16-bit term (f_out) on each f_valid pulse.
// - Converts the term to 5 BCD digits with a sequential double-dabble engine.
// - Time-multiplexes the digits onto the board's 8-digit active-low 7-segment display.
// PARAMETERS
// - REFRESH_DIV  50000  clk cycles each digit stays lit before the scan advances (>=2)
// PORTS
// - clk      in   1   system clock
// - rst      in   1   synchronous reset, active-high
// - f_valid  in   1   single-cycle strobe, f_out valid this cycle
// - f_out    in   16  binary Fibonacci term
// - busy     out  1   conversion in progress
// - bcd      out  20  last completed conversion, digit4..digit0 at [19:16]..[3:0]
// - an       out  8   digit anodes, active-low; an[0] = rightmost digit
// - dec_ddp  out  8   segments, active-low: [7:1] = a..g, [0] = dp
// BEHAVIOUR
// - Reset (synchronous, active-high; clk is the only clock): all outputs and state are cleared.
//   - FSM to IDLE; bcd=0; busy=0; pending flag cleared.
//   - Scan index=0, refresh counter=0, an=8'hFE, dec_ddp = pattern for '0' (8'b0000_0011).
// - FSM states: IDLE, CONV, DONE.
// - IDLE: when f_valid=1, load shift reg {20'b0, f_out}, set iter=0, go to CONV; busy=1 from the next cycle.
// - CONV: one iteration per cycle.
//   - Each 4-bit BCD nibble >=5 gets +3, then the 36-bit register shifts left by 1.
//   - After 16 iterations go to DONE.
// - DONE: copy the BCD field to bcd, then:
//   - go to CONV with the pending value if the pending flag is set (clear the flag);
//   - otherwise go to IDLE.
//   - busy=0 on the cycle after DONE, unless a pending conversion restarts.
// - Latency: f_valid at cycle T (IDLE) -> bcd updated at rising edge T+18, stable from T+18.
// - f_valid during CONV/DONE: latch f_out into a one-deep pending register and set the flag.
//   - A further f_valid overwrites the pending value (newest wins); no loss signalled.
// - f_valid in DONE with the pending flag clear: the new value becomes pending and starts immediately.
// - bcd only changes in DONE, so the display never shows a partially converted value.
// - Max input 65535 -> 0x65535; no overflow is possible in 20 bits.
// - Refresh counter: counts 0..REFRESH_DIV-1.
//   - On wrap, scan index increments 0..7 and wraps to 0.
//   - an has exactly one low bit: an = ~(8'b1 << idx).
// - Digits idx 0..4 show bcd nibble idx (hex 0-9).
//   - Nibble values >9 cannot occur; if forced, show all segments off.
// - Digits idx 5..7: an driven low per scan, segments all off (8'hFF).
// - dp is always 1 (off).
// - an and dec_ddp are registered together: both change on the same edge, no ghosting cycle.
// - Reset asserted mid-conversion: the conversion is aborted and bcd returns to 0 on the next edge.
// CONFIGURATION
// - Macro LEADING_ZERO_BLANK_EN.
// - Defined: digits idx 4..1 blank (dec_ddp=8'hFF) while they and every higher digit are 0.
//   - digit 0 is always shown, e.g. 610 displays as "  610".
// - Undefined: all five digits shown, e.g. "00610".
// - bcd port and latency are identical in both builds.
// TESTING
// - Reset, then f_valid with f_out=610 at T.
//   - busy=1 for T+1..T+17; bcd=20'h00610 at T+18; busy=0 at T+18.
// - f_out=65535 -> bcd=20'h65535; f_out=0 -> bcd=20'h00000 after 18 cycles.
// - Back-to-back pulses 89 (T), then 144 (T+3) and 233 (T+5) during CONV.
//   - bcd=20'h00089 at T+18; bcd=20'h00233 at T+35.
//   - 144 never appears on bcd.
// - Assert rst at T+8 of a conversion of 4181.
//   - bcd=0, busy=0 and an=8'hFE next edge; no later update without a new f_valid.
// - REFRESH_DIV=4, bcd=20'h12345: an steps FE,FD,FB,F7,EF,DF,BF,7F every 4 cycles, then wraps to FE.
//   - dec_ddp shows '5','4','3','2','1', then 8'hFF for idx 5..7.
// - Leading-zero blanking, bcd=20'h00021:
//   - with LEADING_ZERO_BLANK_EN: idx 2..4 give 8'hFF;
//   - without it: idx 2..4 show '0' (8'b0000_0011).

Source files
------------

// File: rtl/fib_bcd_display.sv
// fib_bcd_display: binary-to-BCD converter and 8-digit 7-segment scanner
// for the Fibonacci generator output.
//
// Ports:
//   clk      system clock
//   rst      synchronous reset, active-high
//   f_valid  single-cycle strobe, f_out valid this cycle
//   f_out    16-bit binary term
//   busy     conversion in progress
//   bcd      last completed conversion, digit4..digit0 at [19:16]..[3:0]
//   an       digit anodes, active-low, an[0] = rightmost digit
//   dec_ddp  segments, active-low, [7:1] = a..g, [0] = dp
//
// Parameter REFRESH_DIV: clk cycles each digit stays lit (>= 2).
// Macro LEADING_ZERO_BLANK_EN: blank leading zero digits 4..1.
module fib_bcd_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_valid,
    input  logic [15:0] f_out,
    output logic        busy,
    output logic [19:0] bcd,
    output logic [7:0]  an,
    output logic [7:0]  dec_ddp
);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    state_t      state;
    logic [35:0] sh;
    logic [35:0] sh_adj;
    logic [3:0]  iter;
    logic        pend;
    logic [15:0] pend_val;
    logic [15:0] restart_val;

    // Add-3 correction on every BCD nibble before the shift.
    always_comb begin
        sh_adj = sh;
        for (int i = 0; i < 5; i++) begin
            if (sh[16+4*i +: 4] >= 4'd5) begin
                sh_adj[16+4*i +: 4] = sh[16+4*i +: 4] + 4'd3;
            end
        end
    end

    // A strobe arriving in DONE is newer than any pending value.
    assign restart_val = f_valid ? f_out : pend_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sh       <= '0;
            iter     <= '0;
            pend     <= 1'b0;
            pend_val <= '0;
            busy     <= 1'b0;
            bcd      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (f_valid) begin
                        sh    <= {20'd0, f_out};
                        iter  <= '0;
                        busy  <= 1'b1;
                        state <= CONV;
                    end
                end
                CONV: begin
                    sh   <= {sh_adj[34:0], 1'b0};
                    iter <= iter + 4'd1;
                    if (iter == 4'd15) begin
                        state <= DONE;
                    end
                    if (f_valid) begin
                        pend     <= 1'b1;
                        pend_val <= f_out;
                    end
                end
                DONE: begin
                    bcd  <= sh[35:16];
                    pend <= 1'b0;
                    if (f_valid || pend) begin
                        sh    <= {20'd0, restart_val};
                        iter  <= '0;
                        state <= CONV;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'b0000_0011;
            4'd1:    s = 8'b1001_1111;
            4'd2:    s = 8'b0010_0101;
            4'd3:    s = 8'b0000_1101;
            4'd4:    s = 8'b1001_1001;
            4'd5:    s = 8'b0100_1001;
            4'd6:    s = 8'b0100_0001;
            4'd7:    s = 8'b0001_1111;
            4'd8:    s = 8'b0000_0001;
            4'd9:    s = 8'b0000_1001;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [31:0]   bcd_pad;
    logic [3:0]    nib;
    logic [7:0]    lz;
    logic          blank;
    logic [7:0]    seg_nxt;

    assign bcd_pad = {12'd0, bcd};
    assign nib     = bcd_pad[{idx, 2'b00} +: 4];

    // lz[k]: digit k and every digit above it are zero.
    always_comb begin
        lz    = '0;
        lz[4] = (bcd[19:16] == 4'd0);
        lz[3] = lz[4] && (bcd[15:12] == 4'd0);
        lz[2] = lz[3] && (bcd[11:8] == 4'd0);
        lz[1] = lz[2] && (bcd[7:4] == 4'd0);
    end

`ifdef LEADING_ZERO_BLANK_EN
    assign blank = lz[idx];
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        seg_nxt = 8'hFF;
        if (idx <= 3'd4 && !blank) begin
            seg_nxt = seg7(nib);
        end
    end

    // an and dec_ddp come from the same idx and register on the
    // same edge, so no cycle pairs one digit's anode with another's
    // segments.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            idx     <= '0;
            an      <= 8'hFE;
            dec_ddp <= 8'b0000_0011;
        end else begin
            if (cnt == CNT_MAX) begin
                cnt <= '0;
                idx <= idx + 3'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            an      <= ~(8'h01 << idx);
            dec_ddp <= seg_nxt;
        end
    end

    logic unused_lz;
    assign unused_lz = ^{lz[7:5], lz[0]};

endmodule

// File: tb/tb_fib_bcd_display.sv
// tb_fib_bcd_display: scoreboard bench for fib_bcd_display.
// Expected bcd/busy observations are queued per cycle and checked.
module tb_fib_bcd_display;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        f_valid = 1'b0;
    logic [15:0] f_out = '0;
    logic        busy;
    logic [19:0] bcd;
    logic [7:0]  an;
    logic [7:0]  dec_ddp;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit seen144 = 1'b0;

    typedef struct {
        int          cyc;
        logic [19:0] bcd;
        logic        busy;
        string       tag;
    } exp_t;

    exp_t sb[$];

    logic [7:0] seg_tab [10] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
        8'h49, 8'h41, 8'h1F, 8'h01, 8'h09
    };
    logic [7:0] an_tab [8] = '{
        8'hFE, 8'hFD, 8'hFB, 8'hF7,
        8'hEF, 8'hDF, 8'hBF, 8'h7F
    };

    fib_bcd_display #(
        .REFRESH_DIV(DIV)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .f_valid(f_valid),
        .f_out  (f_out),
        .busy   (busy),
        .bcd    (bcd),
        .an     (an),
        .dec_ddp(dec_ddp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [7:0] exp_seg(input int v, input int k);
        int p;
        if (k > 4) return 8'hFF;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
`ifdef LEADING_ZERO_BLANK_EN
        if (k > 0 && (v / p) == 0) return 8'hFF;
`endif
        return seg_tab[(v / p) % 10];
    endfunction

    task automatic expect_at(input int c, input logic [19:0] b,
                             input logic bz, input string tag);
        exp_t e;
        int i;
        e.cyc  = c;
        e.bcd  = b;
        e.busy = bz;
        e.tag  = tag;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= c) i++;
        sb.insert(i, e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bcd == 20'h00144) seen144 = 1'b1;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                chk({e.tag, "_late"}, cyc, e.cyc);
            end else begin
                chk({e.tag, "_bcd"}, {12'd0, bcd}, {12'd0, e.bcd});
                chk({e.tag, "_busy"}, {31'd0, busy}, {31'd0, e.busy});
            end
        end
    end

    task automatic drive(input logic [15:0] v);
        f_valid = 1'b1;
        f_out   = v;
        @(negedge clk);
        f_valid = 1'b0;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() > 0; i++) @(negedge clk);
        chk("sb_drain", sb.size(), 0);
        sb.delete();
        @(negedge clk);
    endtask

    task automatic conv(input int v, input logic [19:0] prev,
                        input string tag);
        int t0;
        t0 = cyc;
        expect_at(t0 + 1, prev, 1'b1, {tag, "_t1"});
        expect_at(t0 + 17, prev, 1'b1, {tag, "_t17"});
        expect_at(t0 + 18, to_bcd(v), 1'b0, {tag, "_t18"});
        drive(16'(v));
        drain();
    endtask

    task automatic scan_check(input int v, input string tag);
        int k;
        for (int i = 0; i < 100 && an !== 8'h7F; i++) @(negedge clk);
        for (int i = 0; i < 100 && an !== 8'hFE; i++) @(negedge clk);
        chk({tag, "_sync"}, {24'd0, an}, 32'hFE);
        for (int s = 0; s < 9; s++) begin
            k = s % 8;
            chk($sformatf("%s_an%0d", tag, s), {24'd0, an},
                {24'd0, an_tab[k]});
            chk($sformatf("%s_seg%0d", tag, s), {24'd0, dec_ddp},
                {24'd0, exp_seg(v, k)});
            repeat (DIV) @(negedge clk);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int t0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_bcd", {12'd0, bcd}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_an", {24'd0, an}, 32'hFE);
        chk("rst_seg", {24'd0, dec_ddp}, 32'h03);

        conv(610, 20'h00000, "c610");
        conv(65535, 20'h00610, "cmax");
        conv(0, 20'h65535, "czero");

        t0 = cyc;
        expect_at(t0 + 18, 20'h00089, 1'b1, "b2b89");
        expect_at(t0 + 34, 20'h00089, 1'b1, "b2b_hold");
        drive(16'd89);
        wait_cyc(t0 + 3);
        drive(16'd144);
        wait_cyc(t0 + 5);
        expect_at(t0 + 35, 20'h00233, 1'b0, "b2b233");
        drive(16'd233);
        drain();
        chk("no144", {31'd0, seen144}, 0);

        t0 = cyc;
        expect_at(t0 + 18, 20'h00005, 1'b1, "dn5");
        expect_at(t0 + 35, 20'h00007, 1'b0, "dn7");
        drive(16'd5);
        wait_cyc(t0 + 17);
        drive(16'd7);
        drain();

        t0 = cyc;
        expect_at(t0 + 1, 20'h00007, 1'b1, "ab_t1");
        expect_at(t0 + 8, 20'h00007, 1'b1, "ab_t8");
        drive(16'd4181);
        wait_cyc(t0 + 8);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("ab_bcd", {12'd0, bcd}, 0);
        chk("ab_busy", {31'd0, busy}, 0);
        chk("ab_an", {24'd0, an}, 32'hFE);
        repeat (30) @(negedge clk);
        chk("ab_late_bcd", {12'd0, bcd}, 0);
        chk("ab_late_busy", {31'd0, busy}, 0);
        chk("ab_sb", sb.size(), 0);
        sb.delete();

        conv(12345, 20'h00000, "c12345");
        scan_check(12345, "s12345");
        conv(21, 20'h12345, "c21");
        scan_check(21, "s21");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
